add_sub_32: RTL and testbench

32-bit registered two's-complement adder/subtractor. `sel` picks add (`a + b`) or subtract (`a - b`). The result and carry-out are captured in output registers one clock after the operands are sampled. The block is the arithmetic core of the ALU datapath, and the ALU result mux consumes `sum` and `cout` directly.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/cla_4.sv | 31 +++
 rtl/add_sub_32.sv | 55 +++++
 tb/tb_add_sub_32.sv | 128 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, word type and operation-select encodings,
// plus the 4-bit lookahead carry function reused at the second level.
package alu_pkg;

    localparam int ALU_W = 32;

    typedef logic [ALU_W-1:0] word_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Flat sum-of-products carries out of four (generate, propagate) positions.
    // c[i] is the carry out of position i; no carry depends on another carry.
    function automatic logic [3:0] cla_carries(input logic [3:0] g,
                                               input logic [3:0] p,
                                               input logic       cin);
        logic [3:0] c;
        c[0] = g[0] | (p[0] & cin);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

endpackage

// File: rtl/cla_4.sv
// 4-bit carry-lookahead group: local sum plus group generate/propagate for the
// second-level lookahead unit.
module cla_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       g,
    output logic       p
);

    logic [3:0] gi;
    logic [3:0] pi;
    logic [3:1] c;

    assign gi = a & b;
    assign pi = a ^ b;

    assign c[1] = gi[0] | (pi[0] & cin);
    assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
    assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
                | (pi[2] & pi[1] & pi[0] & cin);

    assign sum = pi ^ {c[3:1], cin};

    // Group terms exclude cin so the upper level can compute carries in parallel.
    assign g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
             | (pi[3] & pi[2] & pi[1] & gi[0]);
    assign p = &pi;

endmodule

// File: rtl/add_sub_32.sv
// Registered 32-bit two's-complement adder/subtractor built from eight cla_4
// groups and a two-level lookahead; cout is carry (add) or NOT borrow (subtract).
module add_sub_32
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ALU_W-1:0]  a,
    input  logic [ALU_W-1:0]  b,
    input  logic              sel,
    output logic [ALU_W-1:0]  sum,
    output logic              cout
);

    localparam int NGRP = ALU_W / 4;

    word_t           bx;
    word_t           sum_next;
    logic [NGRP-1:0] grp_g;
    logic [NGRP-1:0] grp_p;
    logic [NGRP:0]   grp_c;

    // Subtract is a + ~b + 1, with the +1 entering as the carry-in.
    assign bx       = (sel == OP_SUB) ? ~b : b;
    assign grp_c[0] = sel;

    for (genvar i = 0; i < NGRP; i++) begin : g_grp
        cla_4 u_cla (
            .a   (a[4*i +: 4]),
            .b   (bx[4*i +: 4]),
            .cin (grp_c[i]),
            .sum (sum_next[4*i +: 4]),
            .g   (grp_g[i]),
            .p   (grp_p[i])
        );
    end

    // Second level: c4..c16 from the low four groups, c20..c32 from the high four
    // seeded by c16.
    assign grp_c[4:1] = cla_carries(grp_g[3:0], grp_p[3:0], grp_c[0]);
    assign grp_c[8:5] = cla_carries(grp_g[7:4], grp_p[7:4], grp_c[4]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: registers take non-blocking assignments so every flop samples
            // pre-edge values regardless of process evaluation order.
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= sum_next;
            cout <= grp_c[NGRP];
        end
    end

endmodule

// File: tb/tb_add_sub_32.sv
// Self-checking bench for add_sub_32: directed literal cases, then randomized
// traffic with sporadic resets against a one-cycle-delayed arithmetic model.
module tb_add_sub_32;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        sel;
    logic [31:0] sum;
    logic        cout;

    logic [31:0] exp_sum;
    logic        exp_cout;
    logic        model_valid;

    int tests_run;
    int tests_failed;

    add_sub_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sel   (sel),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [32:0] got, input logic [32:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got cout=%0b sum=%h, expected cout=%0b sum=%h",
                     name, got[32], got[31:0], want[32], want[31:0]);
        end
    endtask

    // Reference: what the registers must hold after this edge, from the
    // arithmetic definition of add, and of subtract as difference plus no-borrow.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_sum     <= 32'h0;
            exp_cout    <= 1'b0;
            model_valid <= 1'b1;
        end else if (sel) begin
            exp_sum  <= a - b;
            exp_cout <= (a >= b);
        end else begin
            exp_sum  <= 32'(({1'b0, a} + {1'b0, b}));
            exp_cout <= 1'(({1'b0, a} + {1'b0, b}) >> 32);
        end
    end

    always @(negedge clk) begin
        if (model_valid)
            check("model", {cout, sum}, {exp_cout, exp_sum});
    end

    // Apply one cycle of inputs, then check the registered result after the edge.
    task automatic step(input string name, input logic rn, input logic [31:0] ta,
                        input logic [31:0] tb, input logic ts,
                        input logic [31:0] want_sum, input logic want_cout);
        rst_n = rn;
        a     = ta;
        b     = tb;
        sel   = ts;
        @(posedge clk);
        #1;
        check(name, {cout, sum}, {want_cout, want_sum});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        model_valid  = 1'b0;
        rst_n        = 1'b0;
        a            = 32'hFFFF_FFFF;
        b            = 32'h1;
        sel          = 1'b0;
        #1;

        step("reset_0",    1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b0);
        step("reset_1",    1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b0);
        step("reset_rel",  1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1);
        step("sub_24_10",  1'b1, 32'd24, 32'd10, 1'b1, 32'd14, 1'b1);
        step("add_0_0",    1'b1, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        step("add_8_2",    1'b1, 32'd8, 32'd2, 1'b0, 32'd10, 1'b0);
        step("add_5_2",    1'b1, 32'd5, 32'd2, 1'b0, 32'd7, 1'b0);
        step("add_ffff_1", 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1);
        step("add_7fff_1", 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0);
        step("sub_3_5",    1'b1, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0);
        step("sub_0_0",    1'b1, 32'd0, 32'd0, 1'b1, 32'h0, 1'b1);
        step("sub_a_0",    1'b1, 32'hDEAD_BEEF, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        step("sub_eq",     1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0, 1'b1);
        step("add_grp",    1'b1, 32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 32'h1000_0000, 1'b0);
        step("mid_reset",  1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b0);
        step("post_reset", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1);

        // Random regression with occasional resets and boundary-biased operands.
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(99) != 0);
            sel   = 1'($urandom_range(1));
            a     = $urandom;
            b     = $urandom;
            case ($urandom_range(15))
                0: b = 32'h0;
                1: b = a;
                2: a = 32'hFFFF_FFFF;
                3: b = ~a;
                4: b = a + 32'h1;
                default: ;
            endcase
        end

        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
